// File: rtl/addsub_pkg.sv
// Shared constants, result-flag bundle and parameter legality check for the
// pipelined add/subtract unit.
package addsub_pkg;

    localparam int CLA_GROUP = 4;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } addsub_flags_t;

    function automatic bit params_legal(input int width, input int stages);
        return (width > 32'sd0) && (stages > 32'sd0) &&
               ((width % CLA_GROUP) == 32'sd0) &&
               (((width / CLA_GROUP) % stages) == 32'sd0);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational S-bit adder built from 4-bit carry-lookahead groups that ripple
// into one another. Also exposes the carry into the MSB for overflow detection.
module cla_slice
    import addsub_pkg::*;
#(
    parameter int S = 16
) (
    input  logic [S-1:0] i_a,
    input  logic [S-1:0] i_b,
    input  logic         i_cin,
    output logic [S-1:0] o_sum,
    output logic         o_cout,
    output logic         o_c_msb
);

    localparam int NG = S / CLA_GROUP;

    logic [S:0]           w_c;
    logic [CLA_GROUP-1:0] w_p;
    logic [CLA_GROUP-1:0] w_g;
    logic                 w_ci;

    // Lookahead carries inside each group; the group carry-out feeds the next group.
    always_comb begin
        w_c    = {(S+1){1'b0}};
        w_p    = {CLA_GROUP{1'b0}};
        w_g    = {CLA_GROUP{1'b0}};
        w_ci   = 1'b0;
        w_c[0] = i_cin;
        for (int i = 0; i < NG; i++) begin
            w_p  = i_a[i*CLA_GROUP +: CLA_GROUP] ^ i_b[i*CLA_GROUP +: CLA_GROUP];
            w_g  = i_a[i*CLA_GROUP +: CLA_GROUP] & i_b[i*CLA_GROUP +: CLA_GROUP];
            w_ci = w_c[i*CLA_GROUP];
            w_c[i*CLA_GROUP+1] = w_g[0] | (w_p[0] & w_ci);
            w_c[i*CLA_GROUP+2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_ci);
            w_c[i*CLA_GROUP+3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]) |
                                 (w_p[2] & w_p[1] & w_p[0] & w_ci);
            w_c[i*CLA_GROUP+4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1]) |
                                 (w_p[3] & w_p[2] & w_p[1] & w_g[0]) |
                                 (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_ci);
        end
    end

    assign o_sum   = i_a ^ i_b ^ w_c[S-1:0];
    assign o_cout  = w_c[S];
    assign o_c_msb = w_c[S-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined two's-complement add/subtract with valid/ready flow control and
// carry/overflow/zero flags. One S-bit slice of the carry chain per stage.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int S   = WIDTH / STAGES;
    localparam int NOP = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int OW  = (STAGES > 1) ? WIDTH - S : S;

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $fatal(1, "pipe_addsub: WIDTH must be a multiple of 4 and WIDTH/4 divisible by STAGES");
    end

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic              w_in_ready;
    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH-1:0]  r_s     [STAGES];
    logic [WIDTH-1:0]  w_nxt_s [STAGES];
    logic [OW-1:0]     r_a     [NOP];
    logic [OW-1:0]     r_b     [NOP];
    logic [OW-1:0]     w_nxt_a [NOP];
    logic [OW-1:0]     w_nxt_b [NOP];
    logic [NOP-1:0]    r_c;
    logic [NOP-1:0]    w_nxt_c;
    addsub_flags_t     r_flags;
    addsub_flags_t     w_nxt_flags;

    // Subtraction is A + ~B + 1; the +1 enters as the slice-0 carry-in.
    assign w_b_eff = in_b ^ {WIDTH{in_sub}};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [S-1:0] w_sa;
        logic [S-1:0] w_sb;
        logic [S-1:0] w_ss;
        logic         w_ci;
        logic         w_co;
        logic         w_cm;

        if (k == 0) begin : g_src_in
            assign w_sa       = in_a[S-1:0];
            assign w_sb       = w_b_eff[S-1:0];
            assign w_ci       = in_sub;
            assign w_nxt_s[k] = WIDTH'(w_ss);
        end else begin : g_src_reg
            assign w_sa       = r_a[k-1][S-1:0];
            assign w_sb       = r_b[k-1][S-1:0];
            assign w_ci       = r_c[k-1];
            assign w_nxt_s[k] = r_s[k-1] | (WIDTH'(w_ss) << (k*S));
        end

        cla_slice #(.S(S)) u_cla (
            .i_a     (w_sa),
            .i_b     (w_sb),
            .i_cin   (w_ci),
            .o_sum   (w_ss),
            .o_cout  (w_co),
            .o_c_msb (w_cm)
        );

        // Operands are kept shifted so the next slice always sits in the low bits.
        if (k < STAGES - 1) begin : g_fwd
            logic w_cm_unused;
            assign w_cm_unused = w_cm;
            assign w_nxt_c[k]  = w_co;
            if (k == 0) begin : g_op_in
                assign w_nxt_a[k] = in_a[WIDTH-1:S];
                assign w_nxt_b[k] = w_b_eff[WIDTH-1:S];
            end else begin : g_op_reg
                assign w_nxt_a[k] = r_a[k-1] >> S;
                assign w_nxt_b[k] = r_b[k-1] >> S;
            end
        end else begin : g_last
            assign w_nxt_flags.cout = w_co;
            assign w_nxt_flags.ovf  = w_cm ^ w_co;
            assign w_nxt_flags.zero = (w_nxt_s[k] == {WIDTH{1'b0}});
        end
    end

    // Advance chain runs from the output back to stage 0 so a full pipe can still stream.
    always_comb begin
        w_adv  = {STAGES{1'b0}};
        w_load = {STAGES{1'b0}};
        w_adv[STAGES-1] = r_v[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = r_v[k] & (~r_v[k+1] | w_adv[k+1]);
        end
        w_in_ready = ~r_v[0] | w_adv[0];
        w_load[0]  = in_valid & w_in_ready;
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = w_adv[k-1];
        end
    end

    // Valid bits and pipeline data; a stage loads only when empty or emptying this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v     <= {STAGES{1'b0}};
            r_c     <= {NOP{1'b0}};
            r_flags <= 3'b000;
            for (int k = 0; k < STAGES; k++) begin
                r_s[k] <= {WIDTH{1'b0}};
            end
            for (int k = 0; k < NOP; k++) begin
                r_a[k] <= {OW{1'b0}};
                r_b[k] <= {OW{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= 1'b1;
                    r_s[k] <= w_nxt_s[k];
                end else if (w_adv[k]) begin
                    r_v[k] <= 1'b0;
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (w_load[k]) begin
                    r_a[k] <= w_nxt_a[k];
                    r_b[k] <= w_nxt_b[k];
                    r_c[k] <= w_nxt_c[k];
                end
            end
            if (w_load[STAGES-1]) begin
                r_flags <= w_nxt_flags;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_v[STAGES-1];
    assign out_sum   = r_s[STAGES-1];
    assign out_cout  = r_flags.cout;
    assign out_ovf   = r_flags.ovf;
    assign out_zero  = r_flags.zero;

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=32, STAGES=2): directed corner cases,
// backpressure, mid-stream reset and randomized streaming against an arithmetic model.
module tb_pipe_addsub;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    int          n_ret = 0;
    res_t        exp_q[$];
    logic        s_ov;
    logic        s_ir;
    res_t        s_out;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_view;

    pipe_addsub #(.WIDTH(32), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: wide unsigned/signed arithmetic, no carry-chain modelling.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        res_t   r;
        longint ua, ub, sa, sb, ur, sr;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ur = sub ? (ua - ub) : (ua + ub);
        sr = sub ? (sa - sb) : (sa + sb);
        r.sum  = ur[31:0];
        r.cout = sub ? (ua >= ub) : (ur > 64'sd4294967295);
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       pick = 32'h0000_0000;
            1:       pick = 32'hFFFF_FFFF;
            2:       pick = 32'h8000_0000;
            3:       pick = 32'h7FFF_FFFF;
            default: pick = 32'($urandom());
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at negedge, sample 1ns later, score the coming edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic ordy);
        res_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        out_ready = ordy;
        #1;
        s_ov  = out_valid;
        s_ir  = in_ready;
        s_out = {out_sum, out_cout, out_ovf, out_zero};
        if (prev_stall) chk("stall_hold", 64'({s_ov, s_out}), 64'(prev_view));
        prev_stall = out_valid && !out_ready;
        prev_view  = {s_ov, s_out};
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 64'(s_out), 64'(e));
                n_ret++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, sub));
            n_acc++;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input res_t want);
        step(1'b1, a, b, sub, 1'b1);
        chk({tag, "_accept"}, 64'(s_ir), 64'd1);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk({tag, "_lat_early"}, 64'(s_ov), 64'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk({tag, "_lat_valid"}, 64'(s_ov), 64'd1);
        chk(tag, 64'(s_out), 64'(want));
    endtask

    initial begin
        int          ret0;
        int          acc0;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_outputs", 64'({out_valid, out_sum, out_cout, out_ovf, out_zero}), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        directed("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        directed("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
        directed("sub_equal", 32'd5,         32'd5,         1'b1, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
        directed("sub_neg",   32'd3,         32'd5,         1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});

        // Backpressure: four ops offered while the consumer stalls for three cycles.
        ret0 = n_ret;
        step(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        chk("bp_accept0", 64'(s_ir), 64'd1);
        step(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
        chk("bp_accept1", 64'(s_ir), 64'd1);
        step(1'b1, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b0);
        chk("bp_full_ready", 64'(s_ir), 64'd0);
        chk("bp_head", 64'({s_ov, s_out}), 64'({1'b1, model(32'h0000_0010, 32'h0000_0020, 1'b0)}));
        step(1'b1, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b0);
        chk("bp_full_ready2", 64'(s_ir), 64'd0);
        step(1'b1, 32'h1234_5678, 32'h1234_5679, 1'b1, 1'b1);
        chk("bp_release_ready", 64'(s_ir), 64'd1);
        step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        drain("bp_drain");
        chk("bp_all_out", 64'(n_ret - ret0), 64'd4);

        // Reset with two operations in flight; nothing may emerge afterwards.
        step(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
        step(1'b1, 32'h3333_3333, 32'h0000_0001, 1'b1, 1'b0);
        chk("rst_second_accept", 64'(s_ir), 64'd1);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h0000_0001; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({out_valid, out_sum, out_cout, out_ovf, out_zero}), 64'd0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("rst_no_stale", 64'(s_ov), 64'd0);
        end

        // Random streaming with random valid/ready against the scoreboard.
        acc0 = n_acc;
        ret0 = n_ret;
        for (int cyc = 0; cyc < 6000 && (n_acc - acc0) < 1000; cyc++) begin
            ra = pick();
            rb = ($urandom_range(0, 9) == 0) ? ra : pick();
            step($urandom_range(0, 9) < 7, ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        chk("stream_accepted", 64'(n_acc - acc0), 64'd1000);
        drain("stream_drain");
        chk("stream_retired", 64'(n_ret - ret0), 64'(n_acc - acc0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined two's-complement add/subtract unit with a valid/ready handshake and result flags. It generalises the team's fixed 32-bit carry-lookahead adder/subtractor in three ways: arbitrary width, a carry chain split across registered pipeline stages, and carry/overflow/zero flags. It feeds the datapath and the multiplier's final carry-propagate stage wherever a registered, back-pressurable adder is needed.

## Interface
- `WIDTH`, default 32: operand width. Must be a multiple of 4.
- `STAGES`, default 2: number of pipeline stages. `(WIDTH/4) % STAGES == 0`.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: the input operation is valid.
- `in_ready` out 1: the unit accepts the operation this cycle.
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B.
- `in_sub` in 1: 0 = A+B, 1 = A−B.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `out_sum` out WIDTH: result, modulo 2^WIDTH.
- `out_cout` out 1: carry out of the MSB. For subtract, 1 means no borrow.
- `out_ovf` out 1: signed overflow.
- `out_zero` out 1: `out_sum == 0`.

## Operation
- Each operation is split into `STAGES` slices of `S = WIDTH/STAGES` bits.
- Stage k adds slice k using 4-bit lookahead groups, rippling between groups within the slice.
- The slice carry-out is registered into stage k+1.
- Operand slices above k travel unchanged in pipeline registers.
- Lower result slices travel unchanged in pipeline registers.
- Subtract: B is inverted bitwise and the carry-in of slice 0 is 1. Add: carry-in is 0.
- `out_ovf` = carry into MSB XOR carry out of MSB. It is computed in the last stage.
- `out_zero` is computed in the last stage from the full registered sum.
- Each stage k holds a valid bit `v[k]`. Stage `STAGES-1` is the output register.
- `adv[STAGES-1] = v[STAGES-1] & out_ready`.
- `adv[k] = v[k] & (!v[k+1] | adv[k+1])`.
- Stage 0 loads when `in_valid & in_ready`.
- `in_ready = !v[0] | adv[0]`. It is combinational from `out_ready` through the chain; this path is accepted.
- A stage keeps its contents and its valid bit while blocked. No bubble is inserted or lost.
- Results leave in acceptance order.
- With `STAGES` entries in flight and `out_ready` held low, `in_ready` is 0.
- Accept and retire in the same cycle are allowed when full. Throughput is then 1/cycle.
- Outputs do not change while `out_valid & !out_ready`.

## Timing
- Latency: an operation accepted at edge t shows `out_valid=1` after edge t+STAGES−1, i.e. STAGES−1 cycles later.
- With `STAGES=1`, the result is registered in the accepting edge.
- Sustained throughput: one operation per cycle while `out_ready=1`.
- Reset (`rst_n=0` at an edge): all `v[k]` := 0, `out_sum` := 0, `out_cout`/`out_ovf`/`out_zero` := 0, all pipeline data registers := 0.
- `in_ready` reads 1 after reset.
- In-flight operations are discarded by reset mid-stream, with no partial output.
- `in_valid` is ignored during the reset cycle.
- Critical path per stage: S-bit grouped carry plus the slice XOR. This sets the `STAGES` choice, not function.

## Structure
- Package `addsub_pkg`: constant `CLA_GROUP = 4`.
- Package `addsub_pkg`: struct `addsub_flags_t {cout, ovf, zero}`.
- Package `addsub_pkg`: elaboration-time check function for the WIDTH/STAGES legality rule. Illegal parameters stop elaboration.
- Sub-module `cla_slice #(S)`: combinational S-bit adder. It takes a, b, cin and returns sum, cout, and carry into its MSB.
- `cla_slice` is built from 4-bit lookahead groups and instantiated once per stage via generate.
- The top level holds only the valid chain, the pipeline registers and the flag logic.

## Test plan
All cases use `WIDTH=32`, `STAGES=2`.
- Add `0x7FFFFFFF + 0x00000001` → sum `0x80000000`, cout 0, ovf 1, zero 0. `out_valid` arrives one cycle after accept.
- Add `0xFFFFFFFF + 0x00000001` → sum `0`, cout 1, ovf 0, zero 1. This also checks the carry crossing from slice 0 into slice 1.
- Sub `5 − 5` → sum `0`, cout 1, zero 1. Sub `3 − 5` → `0xFFFFFFFE`, cout 0, ovf 0. Sub `0x80000000 − 1` → `0x7FFFFFFF`, ovf 1.
- Backpressure:
  - Issue 4 back-to-back ops with `out_ready=0` for 3 cycles.
  - `in_ready` drops once 2 ops are held.
  - After release, all 4 results appear in order with correct values.
  - Outputs are held stable while stalled.
- Streaming: 1000 random ops with random `in_valid`/`out_ready` against a scoreboard of (a ± b) mod 2^32 and the flags. No loss, no duplication.
- Reset mid-stream: drop `rst_n` for 1 cycle with 2 ops in flight → `out_valid=0`, all outputs 0, `in_ready=1` afterwards. No stale result appears.
